rx_det_lanes: RTL
=================

Name: rx_det_lanes

Overview:
- Synthesisable, multi-lane successor to the single-lane behavioural receiver-detect and electrical-idle models.
- Runs a receiver-detect measurement across LANES lanes using a req/ack/done handshake, and queues one pending request.
- Debounces per-lane electrical-idle-exit with a saturating counter.
- Sits between the LTSSM Detect/Polling logic and the PHY analog model.

Parameters:
- LANES, 4: lane count, legal 1..16.
- DET_CYCLES, 1000: measurement window in clk cycles, >=1.
- EI_CYCLES, 1000: consecutive non-idle cycles required to declare EI exit, >=1.

Ports:
- clk  in  1  single block clock.
- rst_n  in  1  asynchronous, active-low reset.
- det_req  in  1  detect request; rising edge starts a measurement.
- lane_present  in  LANES  analog per-lane receiver-present indication.
- ei_in  in  LANES  per-lane raw electrical idle, 1 = idle.
- det_ack  out  1  one-cycle acknowledge of an accepted request.
- det_done  out  1  one-cycle result-valid pulse.
- det_lanes  out  LANES  latched detected-lane mask.
- det_any  out  1  OR of det_lanes.
- busy  out  1  high whenever FSM != IDLE.
- ei_exit  out  LANES  filtered per-lane EI exit.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All outputs 0, FSM = IDLE, pending = 0, req_q = 0, all counters 0.
  - Because req_q resets to 0, a det_req held high through reset is seen as an edge on the first clk after release.
- Edge detect: edge = det_req & ~req_q; req_q registered every cycle.
- FSM states: IDLE, ACK, MEASURE, DONE. All outputs are Moore, registered.
  - IDLE: on edge go to ACK.
  - ACK (1 cycle): det_ack = 1; load cnt = DET_CYCLES-1; go to MEASURE.
  - MEASURE: decrement cnt each cycle. When cnt == 0, capture lane_present into det_lanes and go to DONE. MEASURE therefore lasts exactly DET_CYCLES cycles.
  - DONE (1 cycle): det_done = 1. If pending or edge, clear pending and go to ACK; else go to IDLE.
- Latency: edge sampled at posedge N -> det_ack high in cycle N+1 -> det_done high in cycle N+2+DET_CYCLES.
- Pending requests:
  - An edge seen in ACK or MEASURE sets pending. Further edges while pending = 1 are dropped (depth 1).
  - An edge in DONE is honoured directly, not queued.
- det_lanes / det_any: hold their value until the next capture. det_any is registered alongside det_lanes.
- lane_present is sampled only at the final MEASURE cycle; glitches earlier are ignored.
- EI filter, per lane, counter saturating at EI_CYCLES:
  - ei_in = 1: counter cleared and ei_exit cleared on the same edge, with no hysteresis delay.
  - ei_in = 0: counter increments; ei_exit = 1 once the counter reaches EI_CYCLES (EI_CYCLES consecutive 0 samples).
  - The counter saturates and never wraps.
- Counter width is CNT_W = $clog2(max(DET_CYCLES, EI_CYCLES)+1), computed in the package. Arithmetic is unsigned. Illegal parameters are flagged by an elaboration-time check.
- Reset mid-measurement abandons the measurement with no det_done, and pending is lost.

Optional Feature:
- Macro: RX_DET_RETRY_EN.
- Defined: if the capture at the end of MEASURE yields a zero mask on the first attempt, the FSM reloads cnt and reruns MEASURE once, with no second det_ack. det_done is then issued after the retry with the retry's mask, so worst-case latency is 2+2*DET_CYCLES. A retry flag is cleared on entering ACK.
- Undefined: always a single measurement, and det_done follows the first capture.

Decomposition:
- Package rx_det_pkg holds:
  - state typedef enum {IDLE, ACK, MEASURE, DONE};
  - the count-width function;
  - parameter-legality constants (MAX_LANES = 16).
- One natural sub-module, ei_exit_filter (params EI_CYCLES, CNT_W; ports clk, rst_n, ei_in, ei_exit). It is instantiated LANES times in a generate loop.

Test Plan:
- Basic detect: LANES=4, DET_CYCLES=8, lane_present=4'b1011, det_req edge sampled at posedge N -> det_ack only in cycle N+1; det_done only in cycle N+10; det_lanes=4'b1011, det_any=1; busy high in cycles N+1..N+10.
- Pending request: second det_req edge during MEASURE, lane_present changed to 4'b0001 -> after first det_done, det_ack the next cycle; second det_done with det_lanes=4'b0001. A third edge during that MEASURE triggers one more measurement; further edges beyond depth 1 are dropped.
- EI filter: EI_CYCLES=5, lane 2 ei_in goes low -> ei_exit[2]=1 after the 5th low sample. A 1-cycle return to idle at count 3 -> no assertion, and the count restarts. Holding low 100 cycles -> ei_exit stays 1 with no wrap.
- Reset mid-operation: rst_n low during MEASURE cycle 4 -> all outputs 0 immediately (asynchronous). Release with det_req still high -> new det_ack one cycle after the first post-reset posedge.
- Retry (RX_DET_RETRY_EN defined): lane_present=0 -> det_done at N+2+2*DET_CYCLES with det_lanes=0 and a single det_ack. Undefined: det_done at N+2+DET_CYCLES.
- Edge in DONE cycle -> FSM goes DONE->ACK directly with pending untouched. LANES=1 build passes the same checks.

Source files
------------

// File: rtl/rx_det_pkg.sv
// Shared types and sizing helpers for the multi-lane receiver-detect block.
package rx_det_pkg;

  localparam int MAX_LANES = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    MEASURE,
    DONE
  } det_state_e;

  // One counter width serves both the detect window and the EI debounce.
  function automatic int cnt_width(input int det_cycles, input int ei_cycles);
    int m;
    m = (det_cycles > ei_cycles) ? det_cycles : ei_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ei_exit_filter.sv
// Per-lane electrical-idle-exit debounce: ei_exit rises after EI_CYCLES
// consecutive non-idle samples, clears on the same edge idle returns.
module ei_exit_filter #(
  parameter int EI_CYCLES = 1000,
  parameter int CNT_W     = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ei_in,
  output logic ei_exit
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(EI_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      ei_exit <= 1'b0;
    end else if (ei_in) begin
      cnt_q   <= '0;
      ei_exit <= 1'b0;
    end else if (cnt_q != SAT) begin
      // Saturated count holds ei_exit high without wrapping.
      cnt_q   <= cnt_q + 1'b1;
      ei_exit <= (cnt_q == SAT - 1'b1);
    end
  end

endmodule

// File: rtl/rx_det_lanes.sv
// Multi-lane receiver-detect sequencer with one-deep request queue and
// per-lane EI exit filters. Define RX_DET_RETRY_EN to rerun an empty detect once.
module rx_det_lanes
  import rx_det_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int DET_CYCLES = 1000,
  parameter int EI_CYCLES  = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             det_req,
  input  logic [LANES-1:0] lane_present,
  input  logic [LANES-1:0] ei_in,
  output logic             det_ack,
  output logic             det_done,
  output logic [LANES-1:0] det_lanes,
  output logic             det_any,
  output logic             busy,
  output logic [LANES-1:0] ei_exit
);

  localparam int               CNT_W    = cnt_width(DET_CYCLES, EI_CYCLES);
  localparam logic [CNT_W-1:0] DET_LOAD = CNT_W'(DET_CYCLES - 1);
`ifdef RX_DET_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  if (LANES < 1 || LANES > MAX_LANES || DET_CYCLES < 1 || EI_CYCLES < 1) begin : g_param_chk
    $error("rx_det_lanes: illegal LANES/DET_CYCLES/EI_CYCLES");
  end

  det_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, pend_q, pend_d, retry_q, retry_d;
  logic             req_edge, capture;

  assign req_edge = det_req & ~req_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    retry_d = retry_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: if (req_edge) begin
        state_d = ACK;
        retry_d = 1'b0;
      end
      ACK: begin
        cnt_d   = DET_LOAD;
        state_d = MEASURE;
        if (req_edge) pend_d = 1'b1;
      end
      MEASURE: begin
        if (req_edge) pend_d = 1'b1;
        if (cnt_q == '0) begin
          capture = 1'b1;
          // An empty first capture reruns the window without a new ack.
          if (RETRY_EN && lane_present == '0 && !retry_q) begin
            retry_d = 1'b1;
            cnt_d   = DET_LOAD;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (pend_q || req_edge) begin
          pend_d  = 1'b0;
          retry_d = 1'b0;
          state_d = ACK;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      pend_q    <= 1'b0;
      retry_q   <= 1'b0;
      det_ack   <= 1'b0;
      det_done  <= 1'b0;
      busy      <= 1'b0;
      det_lanes <= '0;
      det_any   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= det_req;
      pend_q   <= pend_d;
      retry_q  <= retry_d;
      det_ack  <= (state_d == ACK);
      det_done <= (state_d == DONE);
      busy     <= (state_d != IDLE);
      if (capture) begin
        det_lanes <= lane_present;
        det_any   <= |lane_present;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ei_exit_filter #(
      .EI_CYCLES(EI_CYCLES),
      .CNT_W    (CNT_W)
    ) u_ei_filt (
      .clk    (clk),
      .rst_n  (rst_n),
      .ei_in  (ei_in[i]),
      .ei_exit(ei_exit[i])
    );
  end

endmodule
